// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared definitions for the core's pipeline stage registers.
//   XLEN / REG_ADDR_W / RESULT_SRC_W : default datapath sizing
//   result_src_e                     : writeback result select encoding
//   ex_mem_bundle_t                  : EX->MEM payload as one packed word
//   ex_mem_bundle_w()                : bit width of an EX->MEM bundle for
//                                      arbitrary field widths
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

    localparam int XLEN         = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int RESULT_SRC_W = 2;

    typedef enum logic [RESULT_SRC_W-1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    // Field order here is the same order the stage register packs its
    // opaque bundle in, so the two views stay interchangeable.
    typedef struct packed {
        logic                    reg_write;
        logic [RESULT_SRC_W-1:0] result_src;
        logic                    mem_write;
        logic [XLEN-1:0]         alu_result;
        logic [XLEN-1:0]         write_data;
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN-1:0]         pc_plus4;
    } ex_mem_bundle_t;

    function automatic int ex_mem_bundle_w(input int data_w,
                                           input int reg_addr_w,
                                           input int result_src_w);
        return 2 + result_src_w + 3 * data_w + reg_addr_w;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// ---------------------------------------------------------------------------
// pipe_skid_slot
// Generic valid/ready pipeline register on an opaque payload.
// With SKID_EN=1 a second (skid) entry absorbs the beat that arrives in the
// cycle the consumer stalls, so ready_o comes straight from a flop and no
// combinational path runs from ready_i back to the producer.  With SKID_EN=0
// only the main entry exists and ready_o follows ready_i combinationally.
//
// Ports
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   flush_i            : synchronous kill of held and incoming beats
//   valid_i, ready_o,  : upstream handshake and payload
//   data_i
//   valid_o, ready_i,  : downstream handshake and payload (main entry)
//   data_o
// ---------------------------------------------------------------------------
module pipe_skid_slot #(
    parameter int WIDTH   = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q;
    logic             in_xfer;
    logic             out_xfer;

    assign valid_o  = (state_q != ST_EMPTY);
    assign data_o   = main_q;
    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

    // Next-state and main-entry load.  Flush wins over every transfer and
    // leaves the data flops untouched; only the occupancy is cleared.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        main_d  = data_i;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = data_i;
                    end else if (in_xfer && SKID_EN) begin
                        // Consumer stalled while a new beat arrived: park it.
                        state_d = ST_TWO;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // ready_o is low here, so only the drain can happen.
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic [WIDTH-1:0] skid_d;

            // Registered ready: only a full buffer refuses a beat.
            assign ready_o = (state_q != ST_TWO);

            always_comb begin
                skid_d = skid_q;
                if (!flush_i && (state_q == ST_ONE) && in_xfer && !out_xfer) begin
                    skid_d = data_i;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_q <= '0;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_no_skid
            // Accept when empty or when the held beat leaves this cycle.
            assign ready_o = !valid_o || ready_i;
            assign skid_q  = '0;
        end
    endgenerate

endmodule

// File: rtl/execute_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// execute_mem_stage_reg
// EX->MEM pipeline register.  Packs the execute-stage result into one
// bundle, holds it in a pipe_skid_slot and gates the two side-effecting
// controls (register write, memory write) with valid so that a bubble can
// never write the register file or memory.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   flush_i             : synchronous kill of held and incoming beats
//   valid_i / ready_o   : execute-side handshake
//   *E_i                : execute-stage result fields
//   valid_o / ready_i   : memory-side handshake
//   *M_o                : memory-stage fields; RegWriteM_o / MemWriteM_o are
//                         forced low while valid_o is low, the rest hold
// ---------------------------------------------------------------------------
module execute_mem_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH       = XLEN,
    parameter int REG_ADDR_WIDTH   = REG_ADDR_W,
    parameter int RESULT_SRC_WIDTH = RESULT_SRC_W,
    parameter bit SKID_EN          = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic                        RegWriteE_i,
    input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcE_i,
    input  logic                        MemWriteE_i,
    input  logic [DATA_WIDTH-1:0]       ALUResultE_i,
    input  logic [DATA_WIDTH-1:0]       WriteDataE_i,
    input  logic [REG_ADDR_WIDTH-1:0]   RdE_i,
    input  logic [DATA_WIDTH-1:0]       PCPlus4E_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        RegWriteM_o,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrcM_o,
    output logic                        MemWriteM_o,
    output logic [DATA_WIDTH-1:0]       ALUResultM_o,
    output logic [DATA_WIDTH-1:0]       WriteDataM_o,
    output logic [REG_ADDR_WIDTH-1:0]   RdM_o,
    output logic [DATA_WIDTH-1:0]       PCPlus4M_o
);

    localparam int BUNDLE_W = ex_mem_bundle_w(DATA_WIDTH, REG_ADDR_WIDTH,
                                              RESULT_SRC_WIDTH);

    logic [BUNDLE_W-1:0] bundle_in;
    logic [BUNDLE_W-1:0] bundle_main;
    logic                reg_write_held;
    logic                mem_write_held;

    // Same field order as ex_mem_bundle_t.
    assign bundle_in = {RegWriteE_i, ResultSrcE_i, MemWriteE_i, ALUResultE_i,
                        WriteDataE_i, RdE_i, PCPlus4E_i};

    pipe_skid_slot #(
        .WIDTH   (BUNDLE_W),
        .SKID_EN (SKID_EN)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (bundle_in),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (bundle_main)
    );

    assign {reg_write_held, ResultSrcM_o, mem_write_held, ALUResultM_o,
            WriteDataM_o, RdM_o, PCPlus4M_o} = bundle_main;

    // The held write enables may be stale after a drain or flush; masking
    // with valid keeps a bubble from touching architectural state.
    assign RegWriteM_o = reg_write_held & valid_o;
    assign MemWriteM_o = mem_write_held & valid_o;

endmodule

// File: tb/tb_execute_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_execute_mem_stage_reg
// Drives a skid-buffered instance (index 0) and a single-register instance
// (index 1) with identical stimulus.  Each instance has an ordered list of
// beats it currently owns; the monitor checks handshake signals and outputs
// against that list every cycle and updates it from the handshake rules.
// ---------------------------------------------------------------------------
module tb_execute_mem_stage_reg;
    import cpu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        rw_i = 1'b0;
    logic [1:0]  rs_i = '0;
    logic        mw_i = 1'b0;
    logic [31:0] alu_i = '0;
    logic [31:0] wd_i = '0;
    logic [4:0]  rd_i = '0;
    logic [31:0] pc_i = '0;

    logic        vo [2];
    logic        ro [2];
    logic        rwo [2];
    logic        mwo [2];
    logic [1:0]  rso [2];
    logic [31:0] aluo [2];
    logic [31:0] wdo [2];
    logic [4:0]  rdo [2];
    logic [31:0] pco [2];

    int total = 0;
    int bad   = 0;

    ex_mem_bundle_t model_q [2][$];
    ex_mem_bundle_t shown   [2];

    always #5 clk = ~clk;

    execute_mem_stage_reg #(.SKID_EN(1'b1)) dut_skid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ro[0]),
        .RegWriteE_i(rw_i), .ResultSrcE_i(rs_i), .MemWriteE_i(mw_i),
        .ALUResultE_i(alu_i), .WriteDataE_i(wd_i), .RdE_i(rd_i), .PCPlus4E_i(pc_i),
        .valid_o(vo[0]), .ready_i(ready_i),
        .RegWriteM_o(rwo[0]), .ResultSrcM_o(rso[0]), .MemWriteM_o(mwo[0]),
        .ALUResultM_o(aluo[0]), .WriteDataM_o(wdo[0]), .RdM_o(rdo[0]), .PCPlus4M_o(pco[0])
    );

    execute_mem_stage_reg #(.SKID_EN(1'b0)) dut_flat (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ro[1]),
        .RegWriteE_i(rw_i), .ResultSrcE_i(rs_i), .MemWriteE_i(mw_i),
        .ALUResultE_i(alu_i), .WriteDataE_i(wd_i), .RdE_i(rd_i), .PCPlus4E_i(pc_i),
        .valid_o(vo[1]), .ready_i(ready_i),
        .RegWriteM_o(rwo[1]), .ResultSrcM_o(rso[1]), .MemWriteM_o(mwo[1]),
        .ALUResultM_o(aluo[1]), .WriteDataM_o(wdo[1]), .RdM_o(rdo[1]), .PCPlus4M_o(pco[1])
    );

    function automatic void chk(input string name, input int d,
                                input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %h want %h", name, d, $time, act, exp);
        end
    endfunction

    // Monitor / reference model.  Inputs only change just after a rising
    // edge, so at the falling edge they hold the values the next edge sees.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("rst_valid", d, 64'(vo[d]), 64'd0);
                chk("rst_ready", d, 64'(ro[d]), 64'd1);
                chk("rst_regwrite", d, 64'(rwo[d]), 64'd0);
                chk("rst_memwrite", d, 64'(mwo[d]), 64'd0);
                chk("rst_fields", d, 64'({rso[d], aluo[d] | wdo[d] | pco[d], rdo[d]}), 64'd0);
                model_q[d].delete();
                shown[d] = '0;
            end else begin
                logic           exp_v;
                logic           exp_r;
                ex_mem_bundle_t cur;
                exp_v = (model_q[d].size() != 0);
                // Instance 0 can hold two beats; instance 1 only one, and
                // may accept when its held beat leaves in the same cycle.
                exp_r = (d == 0) ? (model_q[d].size() < 2) : (!exp_v || ready_i);
                cur = exp_v ? model_q[d][0] : shown[d];
                chk("valid_o", d, 64'(vo[d]), 64'(exp_v));
                chk("ready_o", d, 64'(ro[d]), 64'(exp_r));
                chk("RegWriteM", d, 64'(rwo[d]), 64'(cur.reg_write & exp_v));
                chk("MemWriteM", d, 64'(mwo[d]), 64'(cur.mem_write & exp_v));
                chk("ResultSrcM", d, 64'(rso[d]), 64'(cur.result_src));
                chk("ALUResultM", d, 64'(aluo[d]), 64'(cur.alu_result));
                chk("WriteDataM", d, 64'(wdo[d]), 64'(cur.write_data));
                chk("RdM", d, 64'(rdo[d]), 64'(cur.rd));
                chk("PCPlus4M", d, 64'(pco[d]), 64'(cur.pc_plus4));
                if (exp_v) shown[d] = cur;
                if (flush_i) begin
                    model_q[d].delete();
                end else begin
                    if (exp_v && ready_i) void'(model_q[d].pop_front());
                    if (valid_i && exp_r)
                        model_q[d].push_back('{rw_i, rs_i, mw_i, alu_i, wd_i, rd_i, pc_i});
                end
            end
        end
    end

    task automatic drive(input logic v, input logic r, input logic f,
                         input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc);
        valid_i = v; ready_i = r; flush_i = f;
        rw_i = rw; rs_i = rs; mw_i = mw;
        alu_i = alu; wd_i = wd; rd_i = rd; pc_i = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        drive(1'b0, r, 1'b0, 1'b0, 2'd0, 1'b0, alu_i, wd_i, rd_i, pc_i);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1'b1);

        // Streaming at full rate.
        drive(1, 1, 0, 1, RES_ALU, 0, 32'h10, 32'h1, 5'd1, 32'h104);
        drive(1, 1, 0, 1, RES_MEM, 0, 32'h14, 32'h2, 5'd2, 32'h108);
        drive(1, 1, 0, 0, RES_PC4, 1, 32'h18, 32'h3, 5'd0, 32'h10C);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A then B while stalled, then drain.
        drive(1, 0, 0, 1, RES_ALU, 0, 32'h100, 32'hA, 5'd3, 32'h200);
        drive(1, 0, 0, 1, RES_ALU, 1, 32'h200, 32'hB, 5'd4, 32'h204);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with a store beat C offered in the same cycle.
        drive(1, 0, 0, 1, RES_ALU, 0, 32'h100, 32'hA, 5'd3, 32'h200);
        drive(1, 0, 0, 1, RES_ALU, 0, 32'h200, 32'hB, 5'd4, 32'h204);
        drive(1, 0, 1, 1, RES_MEM, 1, 32'h300, 32'hC, 5'd6, 32'h208);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset while a beat is stalled.
        drive(1, 0, 0, 1, RES_ALU, 0, 32'hDEADBEEF, 32'h55, 5'd5, 32'h300);
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_valid", d, 64'(vo[d]), 64'd0);
            chk("async_rst_regwrite", d, 64'(rwo[d]), 64'd0);
            chk("async_rst_alu", d, 64'(aluo[d]), 64'd0);
            chk("async_rst_rd", d, 64'(rdo[d]), 64'd0);
            chk("async_rst_ready", d, 64'(ro[d]), 64'd1);
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(1, 1, 0, 1, RES_ALU, 0, 32'h44, 32'h66, 5'd7, 32'h304);
        idle(1'b1);

        // Stall then accept-and-replace in the same cycle.
        drive(1, 0, 0, 0, RES_ALU, 0, 32'h500, 32'h0, 5'd8, 32'h400);
        idle(1'b0);
        drive(1, 1, 0, 1, RES_PC4, 0, 32'h600, 32'h0, 5'd9, 32'h404);
        idle(1'b1);
        idle(1'b1);

        // Bubble gating: one writing beat followed by a bubble.
        drive(1, 1, 0, 1, RES_ALU, 1, 32'h700, 32'h77, 5'd10, 32'h408);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 24) == 0, 1'($urandom), 2'($urandom_range(0, 2)),
                  1'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
        end
        idle(1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
